adc_offset_cal: RTL and testbench

Zero-current offset calibration stage for the motor current-sense path. It consumes the filtered ADC word and strobe from the sigma-delta decimator in the core clock domain. It averages 2^CAL_LOG2 samples to learn the zero-current offset, then subtracts that offset from every subsequent sample. It emits a saturated two's-complement current word for the current control loop.

---
 rtl/adc_offset_cal.sv | 84 ++++++++
 tb/tb_adc_offset_cal.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/adc_offset_cal.sv
// adc_offset_cal: learns the zero-current ADC offset by averaging 2^CAL_LOG2 samples,
// then emits saturated signed offset-corrected samples.
module adc_offset_cal #(
    parameter int CAL_LOG2 = 10
) (
    input  logic        c,
    input  logic        rst,
    input  logic [15:0] d,
    input  logic        dv,
    input  logic        cal_start,
    output logic [15:0] q,
    output logic        qv,
    output logic [15:0] offset,
    output logic        offset_valid,
    output logic        cal_busy,
    output logic        cal_done
);
    typedef enum logic {CAL, RUN} state_t;

    localparam int AW = 16 + CAL_LOG2;

    state_t              state_q;
    logic [AW-1:0]       acc_q;
    logic [AW-1:0]       acc_d;
    logic [CAL_LOG2-1:0] cnt_q;
    logic [15:0]         offset_q;
    logic [15:0]         q_q;
    logic [15:0]         q_d;
    logic [16:0]         diff;
    logic                qv_q;
    logic                done_q;
    logic                valid_q;

    always_comb begin
        acc_d = acc_q + {{CAL_LOG2{1'b0}}, d};
        diff  = {1'b0, d} - {1'b0, offset_q};
        // Bits 16 and 15 disagree only when the difference leaves the 16-bit signed range.
        q_d   = (!diff[16] &&  diff[15]) ? 16'h7FFF :
                ( diff[16] && !diff[15]) ? 16'h8000 : diff[15:0];
    end

    always_ff @(posedge c or posedge rst) begin
        if (rst) begin
            state_q  <= CAL;
            acc_q    <= '0;
            cnt_q    <= '0;
            offset_q <= '0;
            q_q      <= '0;
            qv_q     <= 1'b0;
            done_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            qv_q   <= 1'b0;
            done_q <= 1'b0;
            if (cal_start) begin
                state_q <= CAL;
                acc_q   <= '0;
                cnt_q   <= '0;
            end else if (dv && state_q == CAL) begin
                if (cnt_q == '1) begin
                    offset_q <= acc_d[AW-1:CAL_LOG2];
                    state_q  <= RUN;
                    done_q   <= 1'b1;
                    valid_q  <= 1'b1;
                    acc_q    <= '0;
                    cnt_q    <= '0;
                end else begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CAL_LOG2'(1);
                end
            end else if (dv) begin
                q_q  <= q_d;
                qv_q <= 1'b1;
            end
        end
    end

    assign q            = q_q;
    assign qv           = qv_q;
    assign offset       = offset_q;
    assign offset_valid = valid_q;
    assign cal_busy     = (state_q == CAL);
    assign cal_done     = done_q;
endmodule

// File: tb/tb_adc_offset_cal.sv
// tb_adc_offset_cal: directed self-checking bench for adc_offset_cal with CAL_LOG2=2.
module tb_adc_offset_cal;
    logic        c = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] d = '0;
    logic        dv = 1'b0;
    logic        cal_start = 1'b0;
    logic [15:0] q;
    logic        qv;
    logic [15:0] offset;
    logic        offset_valid;
    logic        cal_busy;
    logic        cal_done;
    int checks = 0;
    int errors = 0;

    adc_offset_cal #(.CAL_LOG2(2)) dut (
        .c(c), .rst(rst), .d(d), .dv(dv), .cal_start(cal_start),
        .q(q), .qv(qv), .offset(offset), .offset_valid(offset_valid),
        .cal_busy(cal_busy), .cal_done(cal_done)
    );

    always #5 c = ~c;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic v, input logic [15:0] x, input logic s);
        @(negedge c);
        dv = v;
        d = x;
        cal_start = s;
        @(posedge c);
        #1;
    endtask

    task automatic cal4(input logic [15:0] x);
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, x, 1'b0);
            chk("cal_qv", qv, 0);
        end
    endtask

    initial begin
        repeat (2) @(posedge c);
        @(negedge c) rst = 1'b0;
        #1;
        chk("rst_q", q, 0);
        chk("rst_qv", qv, 0);
        chk("rst_offset", offset, 0);
        chk("rst_valid", offset_valid, 0);
        chk("rst_busy", cal_busy, 1);
        chk("rst_done", cal_done, 0);

        // Power-up calibration: (100+101+102+103)/4 = 101
        tick(1'b1, 16'd100, 1'b0);
        chk("pu_done0", cal_done, 0);
        tick(1'b1, 16'd101, 1'b0);
        tick(1'b1, 16'd102, 1'b0);
        chk("pu_busy3", cal_busy, 1);
        chk("pu_offset_hold", offset, 0);
        tick(1'b1, 16'd103, 1'b0);
        chk("pu_offset", offset, 101);
        chk("pu_done", cal_done, 1);
        chk("pu_busy", cal_busy, 0);
        chk("pu_valid", offset_valid, 1);
        chk("pu_qv", qv, 0);
        tick(1'b0, 16'd0, 1'b0);
        chk("pu_done_pulse", cal_done, 0);

        // RUN subtraction
        tick(1'b1, 16'd150, 1'b0);
        chk("run_q1", q, 16'h0031);
        chk("run_qv1", qv, 1);
        tick(1'b1, 16'd50, 1'b0);
        chk("run_q2", q, 16'hFFCD);
        chk("run_qv2", qv, 1);
        tick(1'b0, 16'd0, 1'b0);
        chk("run_qv_idle", qv, 0);

        // Coincident cal_start and dv: sample discarded
        tick(1'b1, 16'd500, 1'b1);
        chk("coin_qv", qv, 0);
        chk("coin_busy", cal_busy, 1);
        chk("coin_offset", offset, 101);

        // Restart mid-cal
        tick(1'b1, 16'd1000, 1'b0);
        tick(1'b1, 16'd1000, 1'b0);
        tick(1'b0, 16'd0, 1'b1);
        chk("rs_busy", cal_busy, 1);
        tick(1'b1, 16'd200, 1'b0);
        tick(1'b1, 16'd200, 1'b0);
        tick(1'b1, 16'd200, 1'b0);
        chk("rs_done_early", cal_done, 0);
        chk("rs_offset_hold", offset, 101);
        tick(1'b1, 16'd200, 1'b0);
        chk("rs_done", cal_done, 1);
        chk("rs_offset", offset, 200);
        // dv right after calibration uses new offset
        tick(1'b1, 16'd250, 1'b0);
        chk("post_q", q, 16'd50);
        chk("post_qv", qv, 1);
        chk("post_done", cal_done, 0);

        // Negative saturation
        tick(1'b0, 16'd0, 1'b1);
        cal4(16'd60000);
        chk("sat_offset", offset, 60000);
        tick(1'b1, 16'd0, 1'b0);
        chk("sat_neg", q, 16'h8000);

        // Positive saturation after reset
        @(negedge c) begin rst = 1'b1; dv = 1'b0; end
        @(negedge c) rst = 1'b0;
        cal4(16'd0);
        chk("sat0_valid", offset_valid, 1);
        tick(1'b1, 16'd65535, 1'b0);
        chk("sat_pos", q, 16'h7FFF);
        tick(1'b0, 16'd0, 1'b0);

        // Asynchronous reset between clock edges
        #2 rst = 1'b1;
        #1;
        chk("ar_valid", offset_valid, 0);
        chk("ar_offset", offset, 0);
        chk("ar_busy", cal_busy, 1);
        chk("ar_q", q, 0);
        @(negedge c) rst = 1'b0;
        cal4(16'd8);
        chk("ar_recal", offset, 8);
        chk("ar_recal_done", cal_done, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
